game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer for the rhythm game. Generates the 1 ms time base and
//  runs the IDLE/COUNTDOWN/PLAY/PAUSE/DONE flow from start/pause buttons.
//  Drives song time (ms) and a song-datapath reset to the note generator, and
//  consumes its end-of-song flag. Sits between the button debouncers and note_gen.
// PARAMETERS
//  CLKS_PER_MS   1000  clk cycles per 1 ms tick (>=2)
//  MS_PER_SEC    1000  ms ticks per countdown second (reduced in simulation)
//  COUNTDOWN_SEC 3     countdown length in seconds (1..3; o_countdown is 2 bits)
// PORTS
//  clk          in  1   system clock (single clock domain)
//  rst          in  1   synchronous, active-high reset
//  i_btn_start  in  1   debounced start/quit level; rising edge detected internally
//  i_btn_pause  in  1   debounced pause level; rising edge detected internally
//  i_game_end   in  1   end-of-song flag from the note generator (level)
//  o_cur_time   out 32  song time in ms; feeds note_gen i_cur_time
//  o_song_rst   out 1   reset to the note generator / song datapath
//  o_state      out 3   FSM state: IDLE=0 COUNTDOWN=1 PLAY=2 PAUSE=3 DONE=4
//  o_countdown  out 2   remaining countdown seconds (3,2,1); 0 outside COUNTDOWN
//  o_ms_tick    out 1   1-cycle pulse per ms while the prescaler runs
//  o_done       out 1   high in DONE
// BEHAVIOUR
//  Reset (any state, mid-operation included):
//  - state=IDLE; all outputs 0 except o_song_rst=1.
//  - Prescaler, second counters and cur_time are cleared.
//  - Button edge registers are reset to 1, so a button held through reset is not a press.
//  Edge detection: press = btn & ~btn_q; btn_q <= btn every cycle.
//  Prescaler:
//  - cnt 0..CLKS_PER_MS-1; advances only in COUNTDOWN and PLAY, holds its value in PAUSE.
//  - o_ms_tick=1 in the cycle where cnt==CLKS_PER_MS-1 and the prescaler is advancing;
//    cnt wraps to 0 on the next edge.
//  - cnt is cleared on entry to COUNTDOWN and on the COUNTDOWN->PLAY transition.
//  IDLE:
//  - o_song_rst=1, cur_time=0.
//  - start press -> COUNTDOWN with sec=COUNTDOWN_SEC, ms=0. Pause press is ignored.
//  COUNTDOWN:
//  - o_song_rst=1; o_countdown=sec. On each tick ms++; when ms==MS_PER_SEC-1 on a tick, ms=0, sec--.
//  - Tick with sec==1 and ms==MS_PER_SEC-1 -> PLAY. cur_time stays 0.
//  - Start and pause presses are ignored.
//  PLAY:
//  - o_song_rst=0. On each tick cur_time++ on the same edge; saturates at 32'hFFFF_FFFF.
//  - Priority: i_game_end -> DONE, else pause press -> PAUSE. A tick in the same cycle
//    still increments cur_time.
//  PAUSE:
//  - cur_time and cnt are frozen, o_song_rst=0.
//  - Priority: start press -> IDLE (quit), else pause press -> PLAY.
//  - The partial ms is preserved across the pause.
//  DONE:
//  - o_done=1; cur_time frozen; o_song_rst=0, keeping note_gen's end flag visible.
//  - start press -> IDLE.
//  Latency: presses take effect one edge after the rising input. o_state and all outputs
//  are registered, with one exception: o_ms_tick is decoded from the current cnt/state.
//  Illegal state encodings (5..7) -> IDLE on the next edge.
// STRUCTURE
//  - game_pkg: state encodings (ST_IDLE..ST_DONE), default CLKS_PER_MS/MS_PER_SEC.
//  - Sub-module ms_tick_gen: prescaler with run/clear inputs and tick output,
//    parameterised by CLKS_PER_MS. FSM, edge detectors and counters stay in game_ctrl.
// TESTING (CLKS_PER_MS=4, MS_PER_SEC=5, COUNTDOWN_SEC=3)
//  1. Start press from IDLE -> o_countdown 3,2,1 for 5 ticks each; PLAY entered exactly
//     60 clk after the press edge; o_song_rst drops with PLAY; cur_time=0, then 1 four clk later.
//  2. PLAY 10 ms, pause press mid-ms (cnt=2) -> cur_time holds 10 for 100 clk;
//     un-pause -> first tick after 1 clk (cnt resumes at 2->3), cur_time=11.
//  3. i_game_end and pause press in the same PLAY cycle -> DONE (not PAUSE), o_done=1;
//     start press -> IDLE, cur_time=0, o_song_rst=1.
//  4. Start held high across rst release -> stays IDLE; release then press -> COUNTDOWN.
//  5. rst pulse during PLAY at cur_time=7 -> next edge IDLE, all outputs at reset values.
//  6. PAUSE with start and pause pressed in the same cycle -> IDLE.
//     Force cur_time=32'hFFFF_FFFE in PLAY -> after 2 ticks it stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game sequencer: FSM state encodings and
// default timing parameters.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int DEF_CLKS_PER_MS   = 1000;
  localparam int DEF_MS_PER_SEC    = 1000;
  localparam int DEF_COUNTDOWN_SEC = 3;

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms prescaler: counts clk cycles while run is high, holds when run is low,
// and pulses tick on the last count of each millisecond.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_MS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_MAX);

  // Holding (rather than clearing) while stopped keeps a partial ms across a pause.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer: button edge detection, countdown/play/pause/done FSM,
// song-time counter and the song-datapath reset for the note generator.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLKS_PER_MS   = DEF_CLKS_PER_MS,
  parameter int MS_PER_SEC    = DEF_MS_PER_SEC,
  parameter int COUNTDOWN_SEC = DEF_COUNTDOWN_SEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_start,
  input  logic        i_btn_pause,
  input  logic        i_game_end,
  output logic [31:0] o_cur_time,
  output logic        o_song_rst,
  output logic [2:0]  o_state,
  output logic [1:0]  o_countdown,
  output logic        o_ms_tick,
  output logic        o_done
);

  localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(MS_PER_SEC - 1);

  state_t          state, state_nxt;
  logic [1:0]      sec, sec_nxt;
  logic [MS_W-1:0] ms, ms_nxt;
  logic [31:0]     cur_time, time_nxt;
  logic            start_q, pause_q;
  logic            start_press, pause_press;
  logic            run, clr, tick;
  logic            song_rst_r, done_r;
  logic [1:0]      countdown_r;

  assign start_press = i_btn_start & ~start_q;
  assign pause_press = i_btn_pause & ~pause_q;
  assign run         = (state == ST_COUNTDOWN) || (state == ST_PLAY);

  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clr),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    sec_nxt   = sec;
    ms_nxt    = ms;
    time_nxt  = cur_time;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_press) begin
          state_nxt = ST_COUNTDOWN;
          sec_nxt   = 2'(COUNTDOWN_SEC);
          ms_nxt    = '0;
          clr       = 1'b1;
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (ms == MS_MAX) begin
            ms_nxt  = '0;
            sec_nxt = sec - 2'd1;
            if (sec == 2'd1) begin
              state_nxt = ST_PLAY;
              clr       = 1'b1;
            end
          end else begin
            ms_nxt = ms + MS_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (tick && (cur_time != 32'hFFFF_FFFF)) time_nxt = cur_time + 32'd1;
        if (i_game_end)       state_nxt = ST_DONE;
        else if (pause_press) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (start_press)      state_nxt = ST_IDLE;
        else if (pause_press) state_nxt = ST_PLAY;
      end
      ST_DONE: begin
        if (start_press) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Quitting from any state restarts the song from time zero.
    if (state_nxt == ST_IDLE) time_nxt = '0;
  end

  // Outputs are registered from the next-state values so they change with o_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sec         <= '0;
      ms          <= '0;
      cur_time    <= '0;
      start_q     <= 1'b1;
      pause_q     <= 1'b1;
      song_rst_r  <= 1'b1;
      countdown_r <= '0;
      done_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      sec         <= sec_nxt;
      ms          <= ms_nxt;
      cur_time    <= time_nxt;
      start_q     <= i_btn_start;
      pause_q     <= i_btn_pause;
      song_rst_r  <= (state_nxt == ST_IDLE) || (state_nxt == ST_COUNTDOWN);
      countdown_r <= (state_nxt == ST_COUNTDOWN) ? sec_nxt : 2'd0;
      done_r      <= (state_nxt == ST_DONE);
    end
  end

  assign o_cur_time  = cur_time;
  assign o_song_rst  = song_rst_r;
  assign o_state     = state;
  assign o_countdown = countdown_r;
  assign o_ms_tick   = tick;
  assign o_done      = done_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with a shortened time base
// (4 clk per ms, 5 ms per countdown second, 3-second countdown).
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_pause, game_end;
  logic [31:0] cur_time;
  logic        song_rst, ms_tick, done;
  logic [2:0]  state;
  logic [1:0]  countdown;

  int n_cmp  = 0;
  int n_fail = 0;

  game_ctrl #(.CLKS_PER_MS(4), .MS_PER_SEC(5), .COUNTDOWN_SEC(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_start (btn_start),
    .i_btn_pause (btn_pause),
    .i_game_end  (game_end),
    .o_cur_time  (cur_time),
    .o_song_rst  (song_rst),
    .o_state     (state),
    .o_countdown (countdown),
    .o_ms_tick   (ms_tick),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    tick_clk(1);
    btn_start = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    tick_clk(1);
    btn_pause = 1'b0;
  endtask

  // Checks the complete set of idle/reset output values in one place.
  task automatic check_idle(input string tag);
    n_cmp++;
    if (state !== 3'd0 || song_rst !== 1'b1 || countdown !== 2'd0 ||
        done !== 1'b0 || cur_time !== 32'd0 || ms_tick !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s: state=%0d song_rst=%b cd=%0d done=%b time=%0d tick=%b, want 0/1/0/0/0/0",
               tag, state, song_rst, countdown, done, cur_time, ms_tick);
    end
  endtask

  // Runs the full countdown from the press edge and checks every cycle.
  task automatic run_countdown(input string tag);
    int k;
    logic [1:0] exp_cd;
    logic [2:0] exp_st;
    logic       exp_tk;
    for (int c = 1; c <= 60; c++) begin
      tick_clk(1);
      k      = c / 4;
      exp_cd = (c < 60) ? 2'(3 - k / 5) : 2'd0;
      exp_st = (c < 60) ? 3'd1 : 3'd2;
      exp_tk = (c < 60) && (c % 4 == 3);
      n_cmp++;
      if (state !== exp_st || countdown !== exp_cd || ms_tick !== exp_tk) begin
        n_fail++;
        $display("[TB] FAIL %s c=%0d: state=%0d cd=%0d tick=%b, want %0d/%0d/%b",
                 tag, c, state, countdown, ms_tick, exp_st, exp_cd, exp_tk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; game_end = 1'b0;
    tick_clk(2);
    check_idle("reset_values");
    rst = 1'b0;
    tick_clk(1);
    check_idle("after_release");
  endtask

  task automatic test_countdown();
    press_start();
    n_cmp++;
    if (state !== 3'd1 || countdown !== 2'd3 || song_rst !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL cd_entry: state=%0d cd=%0d song_rst=%b, want 1/3/1", state, countdown, song_rst);
    end
    run_countdown("cd_seq");
    n_cmp++;
    if (song_rst !== 1'b0 || cur_time !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL play_entry: song_rst=%b time=%0d, want 0/0", song_rst, cur_time);
    end
    tick_clk(3);
    n_cmp++;
    if (ms_tick !== 1'b1 || cur_time !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL first_tick: tick=%b time=%0d, want 1/0", ms_tick, cur_time);
    end
    tick_clk(1);
    n_cmp++;
    if (cur_time !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL first_ms: time=%0d, want 1", cur_time);
    end
  endtask

  task automatic test_pause();
    tick_clk(36);
    n_cmp++;
    if (cur_time !== 32'd10) begin
      n_fail++;
      $display("[TB] FAIL play_10ms: time=%0d, want 10", cur_time);
    end
    tick_clk(1);
    press_pause();
    n_cmp++;
    if (state !== 3'd3 || ms_tick !== 1'b0 || song_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pause_entry: state=%0d tick=%b song_rst=%b, want 3/0/0", state, ms_tick, song_rst);
    end
    tick_clk(100);
    n_cmp++;
    if (cur_time !== 32'd10 || state !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL pause_hold: time=%0d state=%0d, want 10/3", cur_time, state);
    end
    press_pause();
    n_cmp++;
    if (state !== 3'd2 || ms_tick !== 1'b0 || cur_time !== 32'd10) begin
      n_fail++;
      $display("[TB] FAIL unpause: state=%0d tick=%b time=%0d, want 2/0/10", state, ms_tick, cur_time);
    end
    tick_clk(1);
    n_cmp++;
    if (ms_tick !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL resume_tick: tick=%b, want 1", ms_tick);
    end
    tick_clk(1);
    n_cmp++;
    if (cur_time !== 32'd11) begin
      n_fail++;
      $display("[TB] FAIL resume_time: time=%0d, want 11", cur_time);
    end
  endtask

  task automatic test_done_priority();
    game_end  = 1'b1;
    btn_pause = 1'b1;
    tick_clk(1);
    game_end  = 1'b0;
    btn_pause = 1'b0;
    n_cmp++;
    if (state !== 3'd4 || done !== 1'b1 || song_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL end_vs_pause: state=%0d done=%b song_rst=%b, want 4/1/0", state, done, song_rst);
    end
    tick_clk(6);
    n_cmp++;
    if (state !== 3'd4 || cur_time !== 32'd11 || ms_tick !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_hold: state=%0d time=%0d tick=%b, want 4/11/0", state, cur_time, ms_tick);
    end
    press_start();
    check_idle("done_quit");
  endtask

  task automatic test_held_start();
    tick_clk(1);
    press_pause();
    check_idle("idle_ignores_pause");
    btn_start = 1'b1;
    rst = 1'b1;
    tick_clk(2);
    rst = 1'b0;
    tick_clk(3);
    check_idle("held_start");
    btn_start = 1'b0;
    tick_clk(1);
    press_start();
    n_cmp++;
    if (state !== 3'd1 || countdown !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL start_after_release: state=%0d cd=%0d, want 1/3", state, countdown);
    end
  endtask

  task automatic test_reset_in_play();
    run_countdown("cd_seq2");
    tick_clk(28);
    n_cmp++;
    if (state !== 3'd2 || cur_time !== 32'd7) begin
      n_fail++;
      $display("[TB] FAIL play_7ms: state=%0d time=%0d, want 2/7", state, cur_time);
    end
    rst = 1'b1;
    tick_clk(1);
    check_idle("rst_in_play");
    rst = 1'b0;
    tick_clk(1);
  endtask

  task automatic test_quit_and_saturate();
    press_start();
    run_countdown("cd_seq3");
    tick_clk(1);
    press_pause();
    tick_clk(1);
    n_cmp++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL pause_before_quit: state=%0d, want 3", state);
    end
    btn_start = 1'b1;
    btn_pause = 1'b1;
    tick_clk(1);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    check_idle("pause_quit");
    tick_clk(1);
    press_start();
    run_countdown("cd_seq4");
    tick_clk(1);
    force dut.cur_time = 32'hFFFF_FFFE;
    #1;
    release dut.cur_time;
    tick_clk(2);
    n_cmp++;
    if (ms_tick !== 1'b1 || cur_time !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("[TB] FAIL sat_pre: tick=%b time=%h, want 1/fffffffe", ms_tick, cur_time);
    end
    tick_clk(1);
    n_cmp++;
    if (cur_time !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("[TB] FAIL sat_max: time=%h, want ffffffff", cur_time);
    end
    tick_clk(4);
    n_cmp++;
    if (cur_time !== 32'hFFFF_FFFF || state !== 3'd2) begin
      n_fail++;
      $display("[TB] FAIL sat_hold: time=%h state=%0d, want ffffffff/2", cur_time, state);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_done_priority();
    test_held_start();
    test_reset_in_play();
    test_quit_and_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
